// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding one shared UART transmitter (IDLE -> LOAD -> WAIT).
// Optional WAIT watchdog enabled by defining UART_TX_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_W      = 8,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] data_in,
  output logic [NUM_REQ-1:0]        gnt,
  output logic                      tx_load,
  output logic [DATA_W-1:0]         tx_data,
  input  logic                      tx_done,
  output logic                      busy,
  output logic [2:0]                cur_id,
  output logic                      timeout_err
);

  localparam int unsigned NR = NUM_REQ;

  typedef enum logic [1:0] {IDLE, LOAD, WAIT} state_t;

  state_t            state, state_nx;
  logic [2:0]        last_winner;
  logic [2:0]        win_id;
  logic              win_found;
  logic [2:0]        idx;
  logic [7:0]        req_ext;
  logic [DATA_W-1:0] bytes [8];

  always_comb begin
    for (int unsigned i = 0; i < 8; i++) begin
      bytes[i] = '0;
    end
    for (int unsigned i = 0; i < NR; i++) begin
      bytes[i] = data_in[i*DATA_W +: DATA_W];
    end
  end

  // Offsets 1..NR: the last offset revisits last_winner, so a lone requester always wins.
  always_comb begin
    req_ext   = 8'(req);
    win_id    = '0;
    win_found = 1'b0;
    idx       = '0;
    for (int unsigned i = 1; i <= NR; i++) begin
      idx = 3'((int'(last_winner) + int'(i)) % NUM_REQ);
      if (!win_found && req_ext[idx]) begin
        win_found = 1'b1;
        win_id    = idx;
      end
    end
  end

`ifdef UART_TX_ARB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  logic [CNT_W-1:0] wdog;
  logic             wdog_hit;

  assign wdog_hit = (wdog == CNT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wdog <= '0;
    end else if (state == LOAD) begin
      wdog <= '0;
    end else if (state == WAIT) begin
      wdog <= wdog + 1'b1;
    end
  end
`endif

  always_comb begin
    state_nx    = state;
    gnt         = '0;
    tx_load     = 1'b0;
    timeout_err = 1'b0;
    unique case (state)
      IDLE: begin
        if (win_found) state_nx = LOAD;
      end
      LOAD: begin
        tx_load  = 1'b1;
        gnt      = NUM_REQ'(1) << cur_id;
        state_nx = WAIT;
      end
      WAIT: begin
        if (tx_done) begin
          state_nx = IDLE;
`ifdef UART_TX_ARB_TIMEOUT_EN
        end else if (wdog_hit) begin
          timeout_err = 1'b1;
          state_nx    = IDLE;
`endif
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      last_winner <= 3'(NUM_REQ - 1);
      tx_data     <= '0;
      cur_id      <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && win_found) begin
        tx_data     <= bytes[win_id];
        cur_id      <= win_id;
        last_winner <= win_id;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter (4 requesters, 8-bit data, 16-cycle watchdog).
module tb_uart_tx_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] data_in;
  logic [3:0]  gnt;
  logic        tx_load;
  logic [7:0]  tx_data;
  logic        tx_done;
  logic        busy;
  logic [2:0]  cur_id;
  logic        timeout_err;

  int errors = 0;
  int checks = 0;

  logic [7:0] bytes_ref [4] = '{8'hA5, 8'h22, 8'h33, 8'h44};

  uart_tx_arbiter #(
    .NUM_REQ    (4),
    .DATA_W     (8),
    .TIMEOUT_CYC(16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .data_in    (data_in),
    .gnt        (gnt),
    .tx_load    (tx_load),
    .tx_data    (tx_data),
    .tx_done    (tx_done),
    .busy       (busy),
    .cur_id     (cur_id),
    .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_load(input string tag, input int idx);
    check_eq({tag, "_load"}, 32'(tx_load), 32'd1);
    check_eq({tag, "_gnt"}, 32'(gnt), 32'(4'b0001 << idx));
    check_eq({tag, "_id"}, 32'(cur_id), 32'(idx));
    check_eq({tag, "_data"}, 32'(tx_data), 32'(bytes_ref[idx]));
  endtask

  task automatic run_frame(input string tag, input logic [3:0] r, input int idx);
    req = r;
    step();
    check_load(tag, idx);
    req = '0;
    step();
    check_eq({tag, "_wait_busy"}, 32'(busy), 32'd1);
    check_eq({tag, "_wait_load"}, 32'(tx_load), 32'd0);
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    check_eq({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    logic bad;
    rst     = 1'b1;
    req     = '0;
    tx_done = 1'b0;
    data_in = {bytes_ref[3], bytes_ref[2], bytes_ref[1], bytes_ref[0]};
    step();
    step();
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_gnt", 32'(gnt), 32'd0);
    check_eq("rst_load", 32'(tx_load), 32'd0);
    check_eq("rst_data", 32'(tx_data), 32'd0);
    check_eq("rst_id", 32'(cur_id), 32'd0);
    check_eq("rst_tmo", 32'(timeout_err), 32'd0);
    rst = 1'b0;
    step();
    check_eq("idle_busy", 32'(busy), 32'd0);

    // single requester, latency one cycle, inputs ignored during WAIT
    req = 4'b0001;
    step();
    check_load("t1", 0);
    check_eq("t1_busy", 32'(busy), 32'd1);
    req = 4'b1111;
    data_in[7:0] = 8'h5A;
    step();
    check_eq("t1_w_gnt", 32'(gnt), 32'd0);
    check_eq("t1_w_load", 32'(tx_load), 32'd0);
    for (int i = 0; i < 4; i++) step();
    check_eq("t1_w_busy", 32'(busy), 32'd1);
    check_eq("t1_w_data", 32'(tx_data), 32'hA5);
    check_eq("t1_w_id", 32'(cur_id), 32'd0);
    req = '0;
    data_in[7:0] = bytes_ref[0];
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    check_eq("t1_idle", 32'(busy), 32'd0);
    check_eq("t1_idle_data", 32'(tx_data), 32'hA5);

    // all requesting from reset: 0,1,2,3,0 with tx_done 10 cycles after each load
    rst = 1'b1;
    step();
    rst = 1'b0;
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      step();
      check_load($sformatf("rr%0d", k), k % 4);
      for (int w = 0; w < 9; w++) step();
      check_eq($sformatf("rr%0d_busy", k), 32'(busy), 32'd1);
      tx_done = 1'b1;
      step();
      tx_done = 1'b0;
      check_eq($sformatf("rr%0d_idle", k), 32'(busy), 32'd0);
      check_eq($sformatf("rr%0d_gap", k), 32'(tx_load), 32'd0);
    end
    req = '0;

    // last winner 0: 0010 -> 1, 0110 -> 2, 0010 -> 1 (wraps through 3,0)
    run_frame("w1", 4'b0010, 1);
    run_frame("w2", 4'b0110, 2);
    run_frame("wrap", 4'b0010, 1);

    // tx_done in IDLE and LOAD ignored
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    check_eq("done_idle", 32'(busy), 32'd0);
    req = 4'b0001;
    step();
    check_load("dl", 0);
    tx_done = 1'b1;
    req = '0;
    step();
    tx_done = 1'b0;
    check_eq("done_load_wait", 32'(busy), 32'd1);
    step();
    check_eq("done_load_wait2", 32'(busy), 32'd1);
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    check_eq("dl_idle", 32'(busy), 32'd0);

    // reset mid-frame
    req = 4'b0100;
    step();
    check_load("mr", 2);
    step();
    check_eq("mr_wait", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check_eq("mr_busy", 32'(busy), 32'd0);
    check_eq("mr_gnt", 32'(gnt), 32'd0);
    check_eq("mr_data", 32'(tx_data), 32'd0);
    step();
    check_eq("mr_hold_load", 32'(tx_load), 32'd0);
    check_eq("mr_hold_tmo", 32'(timeout_err), 32'd0);
    rst = 1'b0;
    step();
    check_load("mr_after", 2);
    req = '0;
    step();
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    check_eq("mr_idle", 32'(busy), 32'd0);

    // watchdog: last winner 2, req 0001 -> winner 0
    req = 4'b0001;
    step();
    check_load("wd", 0);
    req = '0;
    step();
`ifdef UART_TX_ARB_TIMEOUT_EN
    bad = 1'b0;
    for (int k = 1; k < 16; k++) begin
      if (!busy || timeout_err) bad = 1'b1;
      step();
    end
    check_eq("wd_early", 32'(bad), 32'd0);
    check_eq("wd_pulse", 32'(timeout_err), 32'd1);
    step();
    check_eq("wd_idle", 32'(busy), 32'd0);
    check_eq("wd_pulse_end", 32'(timeout_err), 32'd0);
    req = 4'b0001;
    step();
    check_load("wp", 0);
    req = '0;
    step();
    for (int k = 1; k < 16; k++) step();
    tx_done = 1'b1;
    #1;
    check_eq("wd_prec", 32'(timeout_err), 32'd0);
    step();
    tx_done = 1'b0;
    check_eq("wd_prec_idle", 32'(busy), 32'd0);
`else
    bad = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (!busy || timeout_err) bad = 1'b1;
      step();
    end
    check_eq("wd_none", 32'(bad), 32'd0);
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    check_eq("wd_none_idle", 32'(busy), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, SHALL set the number of requesters (2..8).
REQ-002 Parameter DATA_W, default 8, SHALL set the width of one byte.
REQ-003 Parameter TIMEOUT_CYC, default 100000, SHALL set the WAIT watchdog limit in clk cycles.
REQ-004 clk  input  1  SHALL be the clock; all state SHALL update on its rising edge.
REQ-005 rst  input  1  SHALL be the reset: asynchronous, active-high.
REQ-006 req  input  NUM_REQ  SHALL carry per-requester level "byte pending" flags.
REQ-007 data_in  input  NUM_REQ*DATA_W  SHALL carry the requester bytes; requester i uses bits [i*DATA_W +: DATA_W].
REQ-008 gnt  output  NUM_REQ  SHALL give a one-hot, one-cycle acceptance pulse to the winning requester.
REQ-009 tx_load  output  1  SHALL give a one-cycle load strobe to the shared UART transmitter.
REQ-010 tx_data  output  DATA_W  SHALL carry the registered byte for the transmitter.
REQ-011 tx_done  input  1  SHALL carry the transmitter's one-cycle end-of-frame pulse.
REQ-012 busy  output  1  SHALL be high whenever the state is not IDLE.
REQ-013 cur_id  output  3  SHALL give the index of the requester owning the current frame.
REQ-014 timeout_err  output  1  SHALL give a one-cycle watchdog-abort pulse.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, LOAD and WAIT.
REQ-016 In IDLE with req != 0, the block SHALL select a winner, register tx_data and cur_id, and enter LOAD on the next edge.
REQ-017 Winner selection SHALL be round-robin: search from index (last_winner+1) mod NUM_REQ upward with wrap, and take the first set req bit.
REQ-018 In LOAD, tx_load and gnt[cur_id] SHALL both be high for exactly one cycle, and the next state SHALL be WAIT.
REQ-019 Latency SHALL be fixed: a req sampled high in IDLE at edge N SHALL produce tx_load and gnt high during cycle N+1.
REQ-020 tx_data SHALL stay stable from LOAD until the next selection in IDLE.
REQ-021 In WAIT, tx_done=1 SHALL return the FSM to IDLE; the next tx_load SHALL therefore come no earlier than 2 cycles after tx_done.
REQ-022 tx_done during IDLE or LOAD SHALL be ignored.
REQ-023 req and data_in changes outside IDLE SHALL have no effect; a requester SHALL deassert req or present its next byte on the cycle after its gnt pulse.
REQ-024 gnt SHALL be 0 in IDLE and WAIT; tx_load SHALL be 0 in IDLE and WAIT.
REQ-025 last_winner SHALL update to cur_id when LOAD is entered.
REQ-026 With a single requester continuously active, that requester SHALL win every arbitration (no starvation by an absent pointer).

Reset
REQ-027 On rst, the state SHALL go to IDLE and last_winner to NUM_REQ-1 (so index 0 has first priority).
REQ-028 On rst, the outputs SHALL be: gnt=0, tx_load=0, tx_data=0, cur_id=0, busy=0, timeout_err=0, watchdog count=0.
REQ-029 Reset asserted mid-frame (LOAD or WAIT) SHALL abort immediately, with no gnt, tx_load or timeout_err emitted afterward for that frame.

Configuration
REQ-030 When macro UART_TX_ARB_TIMEOUT_EN is defined, a counter SHALL clear on entering WAIT and increment each WAIT cycle.
REQ-031 If that counter reaches TIMEOUT_CYC-1 without tx_done, timeout_err SHALL pulse one cycle and the FSM SHALL go to IDLE; tx_done in that same cycle SHALL take precedence, with no error.
REQ-032 When UART_TX_ARB_TIMEOUT_EN is undefined, WAIT SHALL last until tx_done, no counter logic SHALL exist, and timeout_err SHALL be tied to 0.

Verification
REQ-033 After reset, req=4'b0001, byte0=8'hA5 -> tx_load, gnt=4'b0001 and tx_data=8'hA5 one cycle later; busy stays high until tx_done.
REQ-034 req=4'b1111 held with tx_done 10 cycles after each load -> grant order 0,1,2,3,0; each tx_data matches its owner's byte.
REQ-035 req=4'b0110 after winner 1 -> next winner 2; then req=4'b0010 -> winner 1 (wrap from index 3 to 0).
REQ-036 tx_done pulsed in IDLE and in LOAD -> no state change; FSM is still in WAIT one cycle later.
REQ-037 rst asserted in WAIT with req=4'b0100 -> busy=0 immediately; the next grant after release goes to index 2, tx_load follows 1 cycle after release.
REQ-038 With UART_TX_ARB_TIMEOUT_EN, TIMEOUT_CYC=16 and no tx_done -> timeout_err pulses in the 16th WAIT cycle, then IDLE; without the macro -> busy stays high indefinitely.
